// File: rtl/video_fetch_buf.sv
// Line fetch buffer: packs 16-bit DRAM video words into 32-bit groups, queues them, and
// steps a pixel selector through the current group. Optional macro: VFB_ERRCNT_EN (underrun counter).
module video_fetch_buf #(
    parameter int AW    = 2,
    parameter int ZX_PX = 16
) (
    input  logic        clk,
    input  logic        res,
    input  logic        c1,
    input  logic        line_start,
    input  logic        vpix,
    input  logic [1:0]  render_mode,
    input  logic [15:0] dram_rdata,
    input  logic        dram_strb,
    output logic        fetch_req,
    output logic [31:0] data,
    output logic [3:0]  psel,
    output logic        pix_valid,
    output logic        underrun,
    output logic        overflow,
    output logic [7:0]  err_cnt
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_M1 = (AW+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        MODE_ZX = 2'd0,
        MODE_HC = 2'd1,
        MODE_XC = 2'd2,
        MODE_TX = 2'd3
    } mode_t;

    mode_t       r_mode;
    logic        r_phase;
    logic [15:0] r_wlo;
    logic [31:0] r_mem [DEPTH];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;
    logic [31:0] r_data;
    logic [3:0]  r_psel;
    logic        r_pix_valid;
    logic        r_underrun;
    logic        r_overflow;

    logic [AW:0] w_count;
    logic        w_empty;
    logic        w_full;
    logic        w_paired;
    logic [3:0]  w_last;
    logic        w_slot;
    logic        w_consume;
    logic        w_wrap;
    logic        w_pop;
    logic        w_commit;
    logic [31:0] w_commit_word;
    logic        w_push;
    logic        w_drop;
    logic        w_starve;

    assign w_count   = r_wp - r_rp;
    assign w_empty   = (r_wp == r_rp);
    assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign fetch_req = (w_count < DEPTH_M1);

    // ZX and TX carry {attr,gfx} pairs; HC/XC carry one word per group.
    assign w_paired = (r_mode == MODE_ZX) || (r_mode == MODE_TX);
    assign w_last   = w_paired ? 4'(ZX_PX - 1) : ((r_mode == MODE_HC) ? 4'd3 : 4'd1);

    assign w_slot    = c1 && vpix;
    assign w_consume = w_slot && r_pix_valid;
    assign w_wrap    = w_consume && (r_psel == w_last);
    assign w_starve  = w_slot && !r_pix_valid;
    assign w_pop     = !w_empty && (!r_pix_valid || w_wrap);

    assign w_commit      = dram_strb && !line_start && (!w_paired || r_phase);
    assign w_commit_word = w_paired ? {dram_rdata, r_wlo} : {16'h0000, dram_rdata};
    // A pop on the same edge frees the slot being written, so full+pop still accepts.
    assign w_push        = w_commit && (!w_full || w_pop);
    assign w_drop        = w_commit && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp[AW-1:0]] <= w_commit_word;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_mode      <= MODE_ZX;
            r_phase     <= 1'b0;
            r_wlo       <= 16'h0000;
            r_wp        <= '0;
            r_rp        <= '0;
            r_data      <= 32'h0;
            r_psel      <= 4'd0;
            r_pix_valid <= 1'b0;
            r_underrun  <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (line_start) begin
            r_mode      <= mode_t'(render_mode);
            r_phase     <= 1'b0;
            r_wp        <= '0;
            r_rp        <= '0;
            r_data      <= 32'h0;
            r_psel      <= 4'd0;
            r_pix_valid <= 1'b0;
        end else begin
            if (dram_strb && w_paired) begin
                if (!r_phase) begin
                    r_wlo   <= dram_rdata;
                    r_phase <= 1'b1;
                end else begin
                    r_phase <= 1'b0;
                end
            end
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_rp        <= r_rp + 1'b1;
                r_data      <= r_mem[r_rp[AW-1:0]];
                r_psel      <= 4'd0;
                r_pix_valid <= 1'b1;
            end else if (w_wrap) begin
                r_psel      <= 4'd0;
                r_pix_valid <= 1'b0;
            end else if (w_consume) begin
                r_psel <= r_psel + 4'd1;
            end
            if (w_starve) begin
                r_underrun <= 1'b1;
            end
        end
    end

`ifdef VFB_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (res) begin
            r_err_cnt <= 8'h00;
        end else if (!line_start && w_starve && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'h00;
`endif

    assign data      = r_data;
    assign psel      = r_psel;
    assign pix_valid = r_pix_valid;
    assign underrun  = r_underrun;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_video_fetch_buf.sv
// Directed bench for video_fetch_buf: packing, pixel stepping, underrun, overflow, flush and reset.
module tb_video_fetch_buf;

    logic        clk = 1'b0;
    logic        res;
    logic        c1;
    logic        line_start;
    logic        vpix;
    logic [1:0]  render_mode;
    logic [15:0] dram_rdata;
    logic        dram_strb;
    logic        fetch_req;
    logic [31:0] data;
    logic [3:0]  psel;
    logic        pix_valid;
    logic        underrun;
    logic        overflow;
    logic [7:0]  err_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    logic [15:0] hc_w [4];

`ifdef VFB_ERRCNT_EN
    localparam logic [7:0] ERR_ONE = 8'd1;
`else
    localparam logic [7:0] ERR_ONE = 8'd0;
`endif

    video_fetch_buf #(.AW(2), .ZX_PX(16)) dut (
        .clk         (clk),
        .res         (res),
        .c1          (c1),
        .line_start  (line_start),
        .vpix        (vpix),
        .render_mode (render_mode),
        .dram_rdata  (dram_rdata),
        .dram_strb   (dram_strb),
        .fetch_req   (fetch_req),
        .data        (data),
        .psel        (psel),
        .pix_valid   (pix_valid),
        .underrun    (underrun),
        .overflow    (overflow),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res = 1'b1;
        tick();
        res = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_data"},      data,      32'h0);
        check_val({pfx, "_psel"},      32'(psel), 32'h0);
        check_val({pfx, "_pix_valid"}, 32'(pix_valid), 32'h0);
        check_val({pfx, "_underrun"},  32'(underrun),  32'h0);
        check_val({pfx, "_overflow"},  32'(overflow),  32'h0);
        check_val({pfx, "_err_cnt"},   32'(err_cnt),   32'h0);
        check_val({pfx, "_fetch_req"}, 32'(fetch_req), 32'h1);
    endtask

    task automatic line_with(input logic [1:0] mode, input logic slot, input logic strb,
                             input logic [15:0] word);
        line_start  = 1'b1;
        render_mode = mode;
        c1          = slot;
        vpix        = slot;
        dram_strb   = strb;
        dram_rdata  = word;
        tick();
        line_start = 1'b0;
        c1         = 1'b0;
        vpix       = 1'b0;
        dram_strb  = 1'b0;
    endtask

    task automatic start_line(input logic [1:0] mode);
        line_with(mode, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic strobe(input logic [15:0] word);
        dram_rdata = word;
        dram_strb  = 1'b1;
        tick();
        dram_strb = 1'b0;
    endtask

    task automatic pulse();
        c1   = 1'b1;
        vpix = 1'b1;
        tick();
        c1   = 1'b0;
        vpix = 1'b0;
    endtask

    task automatic pulse_strobe(input logic [15:0] word);
        c1         = 1'b1;
        vpix       = 1'b1;
        dram_rdata = word;
        dram_strb  = 1'b1;
        tick();
        c1        = 1'b0;
        vpix      = 1'b0;
        dram_strb = 1'b0;
    endtask

    initial begin
        res         = 1'b1;
        c1          = 1'b0;
        vpix        = 1'b0;
        line_start  = 1'b0;
        render_mode = 2'd0;
        dram_rdata  = 16'h0000;
        dram_strb   = 1'b0;
        tick();
        tick();
        res = 1'b0;
        check_reset_vals("rst");

        // ZX pair packing and 16-pixel stepping
        start_line(2'd0);
        strobe(16'hAA55);
        check_val("zx_half_pv", 32'(pix_valid), 32'h0);
        strobe(16'h3807);
        check_val("zx_commit_pv", 32'(pix_valid), 32'h0);
        tick();
        check_val("zx_data", data, 32'h3807AA55);
        check_val("zx_pv", 32'(pix_valid), 32'h1);
        check_val("zx_psel0", 32'(psel), 32'h0);
        for (int i = 0; i < 16; i++) begin
            pulse();
            check_val("zx_psel", 32'(psel), (i < 15) ? 32'(i + 1) : 32'h0);
            check_val("zx_step_pv", 32'(pix_valid), (i < 15) ? 32'h1 : 32'h0);
        end
        check_val("zx_data_hold", data, 32'h3807AA55);

        // HC: four single-word groups, 4 pixels each
        hc_w[0] = 16'h1234;
        hc_w[1] = 16'h5678;
        hc_w[2] = 16'h9ABC;
        hc_w[3] = 16'hDEF0;
        start_line(2'd1);
        for (int k = 0; k < 4; k++) strobe(hc_w[k]);
        check_val("hc_fetch_req_lo", 32'(fetch_req), 32'h0);
        for (int g = 0; g < 4; g++) begin
            for (int p = 0; p < 4; p++) begin
                check_val("hc_data", data, {16'h0000, hc_w[g]});
                check_val("hc_psel", 32'(psel), 32'(p));
                pulse();
            end
        end
        check_val("hc_end_pv", 32'(pix_valid), 32'h0);
        check_val("hc_end_fetch_req", 32'(fetch_req), 32'h1);
        check_val("hc_end_data", data, 32'h0000DEF0);
        check_val("hc_no_underrun", 32'(underrun), 32'h0);

        // XC underrun
        start_line(2'd2);
        strobe(16'h00FF);
        check_val("xc_commit_pv", 32'(pix_valid), 32'h0);
        tick();
        check_val("xc_data", data, 32'h000000FF);
        pulse();
        check_val("xc_psel1", 32'(psel), 32'h1);
        pulse();
        check_val("xc_wrap_pv", 32'(pix_valid), 32'h0);
        check_val("xc_wrap_underrun", 32'(underrun), 32'h0);
        pulse();
        check_val("xc_underrun", 32'(underrun), 32'h1);
        check_val("xc_err_cnt", 32'(err_cnt), 32'(ERR_ONE));
        check_val("xc_psel_hold", 32'(psel), 32'h0);
        line_with(2'd2, 1'b1, 1'b0, 16'h0000);
        check_val("ls_slot_err_cnt", 32'(err_cnt), 32'(ERR_ONE));
        check_val("ls_keeps_underrun", 32'(underrun), 32'h1);

        // Overflow: the data register takes the first word, the FIFO the next four
        do_reset();
        check_val("ovf_rst_underrun", 32'(underrun), 32'h0);
        check_val("ovf_rst_err_cnt", 32'(err_cnt), 32'h0);
        start_line(2'd1);
        for (int k = 0; k < 5; k++) begin
            strobe(16'hA000 + 16'(k));
            exp_q.push_back({16'h0000, 16'hA000 + 16'(k)});
        end
        check_val("ovf_fetch_req", 32'(fetch_req), 32'h0);
        check_val("ovf_not_yet", 32'(overflow), 32'h0);
        exp_w = exp_q.pop_front();
        check_val("ovf_data0", data, exp_w);
        for (int p = 0; p < 3; p++) begin
            pulse();
            check_val("ovf_psel", 32'(psel), 32'(p + 1));
        end
        pulse_strobe(16'hA005);
        exp_q.push_back(32'h0000A005);
        exp_w = exp_q.pop_front();
        check_val("full_pop_data", data, exp_w);
        check_val("full_pop_overflow", 32'(overflow), 32'h0);
        check_val("full_pop_fetch_req", 32'(fetch_req), 32'h0);
        strobe(16'hA006);
        check_val("ovf_set", 32'(overflow), 32'h1);
        for (int g = 0; g < 4; g++) begin
            for (int p = 0; p < 4; p++) pulse();
            exp_w = exp_q.pop_front();
            check_val("ovf_readback", data, exp_w);
            check_val("ovf_readback_pv", 32'(pix_valid), 32'h1);
        end
        for (int p = 0; p < 4; p++) pulse();
        check_val("ovf_drain_pv", 32'(pix_valid), 32'h0);
        check_val("ovf_drain_fetch_req", 32'(fetch_req), 32'h1);
        check_val("ovf_drain_data", data, 32'h0000A005);
        check_val("ovf_q_empty", 32'(exp_q.size()), 32'h0);

        // Flush mid-group into TX, with a strobe and a pixel slot on the flush edge
        do_reset();
        start_line(2'd1);
        for (int k = 0; k < 4; k++) strobe(16'hB001 + 16'(k));
        pulse();
        check_val("fl_pre_psel", 32'(psel), 32'h1);
        line_with(2'd3, 1'b1, 1'b1, 16'hBEEF);
        check_val("fl_pv", 32'(pix_valid), 32'h0);
        check_val("fl_psel", 32'(psel), 32'h0);
        check_val("fl_data", data, 32'h0);
        check_val("fl_fetch_req", 32'(fetch_req), 32'h1);
        check_val("fl_no_underrun", 32'(underrun), 32'h0);
        render_mode = 2'd1;
        strobe(16'h1111);
        check_val("tx_half_pv", 32'(pix_valid), 32'h0);
        strobe(16'h2222);
        tick();
        check_val("tx_pair", data, 32'h22221111);
        for (int p = 0; p < 15; p++) pulse();
        check_val("tx_psel15", 32'(psel), 32'hF);
        check_val("tx_pv15", 32'(pix_valid), 32'h1);
        pulse();
        pulse();
        check_val("tx_underrun", 32'(underrun), 32'h1);

        // Reset mid-line with a half-packed pair pending
        strobe(16'h3333);
        do_reset();
        check_reset_vals("mid_rst");
        start_line(2'd0);
        strobe(16'h5555);
        strobe(16'h6666);
        tick();
        check_val("post_rst_pair", data, 32'h66665555);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
